// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch unit.
// Issues byte-wide program memory reads at pc, holds each fetched instruction
// for the decoder until it is accepted, and supports jump redirect and halt.
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst        - synchronous reset, active low
//   memAddr    - program memory read address (always equals pc)
//   memReq     - program memory read request
//   memAck     - memory has data; memData valid in the same cycle
//   memData    - instruction byte from memory
//   inst       - instruction presented to the decoder (NOP_INST when not valid)
//   instValid  - inst holds a fetched instruction
//   instAccept - decoder consumes inst this cycle
//   jumpEn     - redirect fetch to jumpAddr
//   jumpAddr   - redirect target
//   halt       - stop issuing new fetches at the next HOLD exit
//   pc         - address of the next fetch
module inst_fetch #(
  parameter logic [7:0] RESET_VECTOR = 8'h00,
  parameter logic [7:0] NOP_INST     = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] memAddr,
  output logic       memReq,
  input  logic       memAck,
  input  logic [7:0] memData,
  output logic [7:0] inst,
  output logic       instValid,
  input  logic       instAccept,
  input  logic       jumpEn,
  input  logic [7:0] jumpAddr,
  input  logic       halt,
  output logic [7:0] pc
);

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_HOLD,
    S_HALTED
  } state_t;

  state_t     state;
  logic [7:0] fetch_addr;

  assign pc      = fetch_addr;
  assign memAddr = fetch_addr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_RESET;
      fetch_addr <= RESET_VECTOR;
      memReq     <= 1'b0;
      instValid  <= 1'b0;
      inst       <= NOP_INST;
    end else begin
      case (state)
        S_RESET: begin
          if (halt) begin
            state  <= S_HALTED;
            memReq <= 1'b0;
          end else begin
            state  <= S_FETCH;
            memReq <= 1'b1;
          end
        end

        // halt is deliberately not looked at here: an outstanding request
        // always completes into HOLD.
        S_FETCH: begin
          if (jumpEn) begin
            // jump wins over a same-cycle ack: data dropped, pc not bumped
            fetch_addr <= jumpAddr;
            memReq     <= 1'b1;
            instValid  <= 1'b0;
            inst       <= NOP_INST;
          end else if (memAck) begin
            state      <= S_HOLD;
            inst       <= memData;
            instValid  <= 1'b1;
            fetch_addr <= fetch_addr + 8'd1;
            memReq     <= 1'b0;
          end
        end

        S_HOLD: begin
          if (jumpEn) begin
            state      <= S_FETCH;
            fetch_addr <= jumpAddr;
            memReq     <= 1'b1;
            instValid  <= 1'b0;
            inst       <= NOP_INST;
          end else if (instAccept) begin
            instValid <= 1'b0;
            inst      <= NOP_INST;
            if (halt) begin
              state  <= S_HALTED;
              memReq <= 1'b0;
            end else begin
              state  <= S_FETCH;
              memReq <= 1'b1;
            end
          end
        end

        // a jump leaves HALTED even while halt is still asserted
        S_HALTED: begin
          if (jumpEn) begin
            state      <= S_FETCH;
            fetch_addr <= jumpAddr;
            memReq     <= 1'b1;
          end
          instValid <= 1'b0;
          inst      <= NOP_INST;
        end

        default: begin
          state      <= S_RESET;
          fetch_addr <= RESET_VECTOR;
          memReq     <= 1'b0;
          instValid  <= 1'b0;
          inst       <= NOP_INST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: self-checking bench for inst_fetch.
// Directed scenarios with constant expectations, then randomized traffic
// checked against a behavioural model of the fetch unit.
module tb_inst_fetch;

  logic       clk;
  logic       rst;
  logic [7:0] memAddr;
  logic       memReq;
  logic       memAck;
  logic [7:0] memData;
  logic [7:0] inst;
  logic       instValid;
  logic       instAccept;
  logic       jumpEn;
  logic [7:0] jumpAddr;
  logic       halt;
  logic [7:0] pc;

  int unsigned checks;
  int unsigned errors;

  // behavioural model
  logic [7:0] m_pc;
  logic [7:0] m_inst;
  logic       m_valid;
  logic       m_in_reset;  // sitting in the post-reset state
  logic       m_halted;
  logic       m_holding;   // an instruction is waiting for the decoder

  inst_fetch #(
    .RESET_VECTOR(8'h00),
    .NOP_INST    (8'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memAddr   (memAddr),
    .memReq    (memReq),
    .memAck    (memAck),
    .memData   (memData),
    .inst      (inst),
    .instValid (instValid),
    .instAccept(instAccept),
    .jumpEn    (jumpEn),
    .jumpAddr  (jumpAddr),
    .halt      (halt),
    .pc        (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_req();
    return !m_in_reset && !m_halted && !m_holding;
  endfunction

  // Advance the model by one edge using the currently driven inputs.
  task automatic model_edge();
    if (!rst) begin
      m_pc = 8'h00; m_inst = 8'h00; m_valid = 1'b0;
      m_in_reset = 1'b1; m_halted = 1'b0; m_holding = 1'b0;
    end else if (m_in_reset) begin
      m_in_reset = 1'b0;
      m_halted   = halt;
    end else if (jumpEn) begin
      m_pc = jumpAddr; m_valid = 1'b0; m_inst = 8'h00;
      m_holding = 1'b0; m_halted = 1'b0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (m_holding) begin
      if (instAccept) begin
        m_holding = 1'b0; m_valid = 1'b0; m_inst = 8'h00;
        m_halted = halt;
      end
    end else if (memAck) begin
      m_inst = memData; m_valid = 1'b1; m_pc = m_pc + 8'd1;
      m_holding = 1'b1;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memAck = 1'b0; memData = 8'h00; instAccept = 1'b0;
    jumpEn = 1'b0; jumpAddr = 8'h00; halt = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] rv;
    rst = 1'b0; idle_inputs();
    step(); step();
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 8'h00); end
    checks++; if (memReq !== 1'b0) begin errors++; $display("FAIL reset_memReq got %b want 0", memReq); end
    checks++; if (instValid !== 1'b0) begin errors++; $display("FAIL reset_instValid got %b want 0", instValid); end
    checks++; if (inst !== 8'h00) begin errors++; $display("FAIL reset_inst got %h want 00", inst); end
    rst = 1'b1; memAck = 1'b1; memData = 8'h0B;
    step();
    checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL edge1_memReq got %b want 1", memReq); end
    checks++; if (memAddr !== 8'h00) begin errors++; $display("FAIL edge1_memAddr got %h want 00", memAddr); end
    step();
    rv = 8'h0B;
    checks++; if (inst !== rv) begin errors++; $display("FAIL edge2_inst got %h want %h", inst, rv); end
    checks++; if (instValid !== 1'b1) begin errors++; $display("FAIL edge2_instValid got %b want 1", instValid); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL edge2_pc got %h want 01", pc); end
  endtask

  task automatic test_accept();
    memAck = 1'b0; instAccept = 1'b1;
    step();
    instAccept = 1'b0;
    checks++; if (instValid !== 1'b0) begin errors++; $display("FAIL accept_instValid got %b want 0", instValid); end
    checks++; if (inst !== 8'h00) begin errors++; $display("FAIL accept_inst got %h want 00", inst); end
    checks++; if (memReq !== 1'b1) begin errors++; $display("FAIL accept_memReq got %b want 1", memReq); end
    checks++; if (memAddr !== 8'h01) begin errors++; $display("FAIL accept_memAddr got %h want 01", memAddr); end
  endtask

  task automatic test_wait_states();
    logic [7:0] d;
    memAck = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      memData = 8'($urandom);
      step();
      checks++; if (memReq !== 1'b1 || memAddr !== 8'h01) begin errors++; $display("FAIL wait_req cycle %0d got req=%b addr=%h want req=1 addr=01", i, memReq, memAddr); end
      checks++; if (instValid !== 1'b0 || inst !== 8'h00) begin errors++; $display("FAIL wait_inst cycle %0d got valid=%b inst=%h want valid=0 inst=00", i, instValid, inst); end
    end
    d = 8'($urandom_range(1, 255));
    memAck = 1'b1; memData = d;
    step();
    memAck = 1'b0;
    checks++; if (inst !== d || instValid !== 1'b1) begin errors++; $display("FAIL wait_ack got inst=%h valid=%b want inst=%h valid=1", inst, instValid, d); end
    checks++; if (pc !== 8'h02) begin errors++; $display("FAIL wait_pc got %h want 02", pc); end
    instAccept = 1'b1;
    step();
    instAccept = 1'b0;
  endtask

  task automatic test_jump_collision();
    jumpEn = 1'b1; jumpAddr = 8'h40; memAck = 1'b1; memData = 8'h5A;
    step();
    jumpEn = 1'b0; memAck = 1'b0;
    checks++; if (pc !== 8'h40) begin errors++; $display("FAIL jcol_pc got %h want 40", pc); end
    checks++; if (instValid !== 1'b0 || inst !== 8'h00) begin errors++; $display("FAIL jcol_inst got valid=%b inst=%h want valid=0 inst=00", instValid, inst); end
    step();
    checks++; if (memAddr !== 8'h40 || memReq !== 1'b1) begin errors++; $display("FAIL jcol_next got addr=%h req=%b want addr=40 req=1", memAddr, memReq); end
    // jump and accept together in HOLD: jump wins even with halt set
    memAck = 1'b1; memData = 8'h77;
    step();
    memAck = 1'b0; jumpEn = 1'b1; jumpAddr = 8'h80; instAccept = 1'b1; halt = 1'b1;
    step();
    jumpEn = 1'b0; instAccept = 1'b0; halt = 1'b0;
    checks++; if (memAddr !== 8'h80 || memReq !== 1'b1 || instValid !== 1'b0) begin errors++; $display("FAIL jacc got addr=%h req=%b valid=%b want addr=80 req=1 valid=0", memAddr, memReq, instValid); end
  endtask

  task automatic test_wrap_halt();
    logic [7:0] d;
    jumpEn = 1'b1; jumpAddr = 8'hFF;
    step();
    jumpEn = 1'b0;
    d = 8'($urandom_range(1, 255));
    memAck = 1'b1; memData = d;
    step();
    memAck = 1'b0;
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL wrap_pc got %h want 00", pc); end
    checks++; if (inst !== d || instValid !== 1'b1) begin errors++; $display("FAIL wrap_inst got inst=%h valid=%b want inst=%h valid=1", inst, instValid, d); end
    halt = 1'b1; instAccept = 1'b1;
    step();
    for (int unsigned i = 0; i < 4; i++) begin
      memAck = 1'($urandom); instAccept = 1'($urandom); memData = 8'($urandom);
      step();
      checks++; if (memReq !== 1'b0 || inst !== 8'h00 || instValid !== 1'b0) begin errors++; $display("FAIL halted cycle %0d got req=%b inst=%h valid=%b want req=0 inst=00 valid=0", i, memReq, inst, instValid); end
    end
    memAck = 1'b0; instAccept = 1'b0; jumpEn = 1'b1; jumpAddr = 8'h10;
    step();
    jumpEn = 1'b0;
    checks++; if (memAddr !== 8'h10 || memReq !== 1'b1) begin errors++; $display("FAIL unhalt got addr=%h req=%b want addr=10 req=1", memAddr, memReq); end
    // halt still high: the fetch completes, then halt applies at accept
    memAck = 1'b1; memData = 8'h33;
    step();
    memAck = 1'b0;
    checks++; if (instValid !== 1'b1 || pc !== 8'h11) begin errors++; $display("FAIL halt_fetch got valid=%b pc=%h want valid=1 pc=11", instValid, pc); end
    instAccept = 1'b1;
    step();
    instAccept = 1'b0;
    checks++; if (memReq !== 1'b0 || instValid !== 1'b0) begin errors++; $display("FAIL halt_exit got req=%b valid=%b want req=0 valid=0", memReq, instValid); end
    halt = 1'b0; jumpEn = 1'b1; jumpAddr = 8'h20;
    step();
    jumpEn = 1'b0;
  endtask

  task automatic test_reset_mid_hold();
    memAck = 1'b1; memData = 8'h99;
    step();
    memAck = 1'b0;
    checks++; if (instValid !== 1'b1) begin errors++; $display("FAIL prehold_valid got %b want 1", instValid); end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++; if (instValid !== 1'b0 || inst !== 8'h00) begin errors++; $display("FAIL rsthold_inst got valid=%b inst=%h want valid=0 inst=00", instValid, inst); end
    checks++; if (pc !== 8'h00 || memReq !== 1'b0) begin errors++; $display("FAIL rsthold_pc got pc=%h req=%b want pc=00 req=0", pc, memReq); end
  endtask

  task automatic test_random();
    for (int unsigned i = 0; i < 500; i++) begin
      rst        = ($urandom_range(0, 39) != 0);
      jumpEn     = ($urandom_range(0, 9) == 0);
      jumpAddr   = 8'($urandom);
      halt       = ($urandom_range(0, 7) == 0);
      memAck     = 1'($urandom);
      memData    = 8'($urandom);
      instAccept = 1'($urandom);
      step();
      checks++;
      if (pc !== m_pc || memAddr !== m_pc || memReq !== m_req() || instValid !== m_valid || inst !== m_inst) begin
        errors++;
        $display("FAIL random cycle %0d got pc=%h addr=%h req=%b valid=%b inst=%h want pc=%h addr=%h req=%b valid=%b inst=%h",
                 i, pc, memAddr, memReq, instValid, inst, m_pc, m_pc, m_req(), m_valid, m_inst);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    m_pc = 8'h00; m_inst = 8'h00; m_valid = 1'b0;
    m_in_reset = 1'b1; m_halted = 1'b0; m_holding = 1'b0;
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_accept();
    test_wait_states();
    test_jump_collision();
    test_wrap_halt();
    test_reset_mid_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
